// File: rtl/grid_ccff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : grid_ccff_pkg
// Brief    : Shared types and helpers for the grid configuration-chain loader.
// Revision : 1.0 - initial release
// ============================================================================
package grid_ccff_pkg;

  // Loader phases; CLEAR is only reachable when the tail check is built in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Counter width able to hold the value CHAIN_LEN itself.
  function automatic int calc_cnt_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/grid_ccff_multichain_loader_tail_checker.sv
`default_nettype none
// ============================================================================
// Module   : ccff_tail_checker
// Brief    : Sticky per-chain error flags raised when a chain tail reads 1
//            during a load shift (stuck-at-1 or over-length chain).
// Revision : 1.0 - initial release
// ============================================================================
module ccff_tail_checker #(
  parameter int NUM_CHAINS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_check_en,
  input  logic [NUM_CHAINS-1:0] i_tail,
  output logic [NUM_CHAINS-1:0] o_err
);

  logic [NUM_CHAINS-1:0] r_err;

  // Accumulate tail ones while load data is shifting; cleared on a new load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= '0;
    end else if (i_clear) begin
      r_err <= '0;
    end else if (i_check_en) begin
      r_err <= r_err | i_tail;
    end
  end

  assign o_err = r_err;

endmodule
`default_nettype wire

// File: rtl/grid_ccff_multichain_loader.sv
`default_nettype none
// ============================================================================
// Module   : grid_ccff_multichain_loader
// Brief    : Loads NUM_CHAINS parallel ccff chains of CHAIN_LEN bits from a
//            valid/ready bitstream, one bit per chain per accepted word.
//            Optional feature macro: CCFF_TAIL_CHECK_EN (zero-fill CLEAR
//            phase plus sticky per-chain tail integrity errors).
// Revision : 1.0 - initial release
// ============================================================================
module grid_ccff_multichain_loader
  import grid_ccff_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 64,
  parameter int CNT_W      = calc_cnt_w(CHAIN_LEN)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic                  bs_valid,
  input  logic [NUM_CHAINS-1:0] bs_data,
  output logic                  bs_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic [CNT_W-1:0]      shift_count,
  output logic [NUM_CHAINS-1:0] cfg_err
);

`ifdef CCFF_TAIL_CHECK_EN
  localparam bit c_tail_chk = 1'b1;
`else
  localparam bit c_tail_chk = 1'b0;
`endif
  localparam logic [CNT_W-1:0] c_last    = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_count;
  logic [NUM_CHAINS-1:0] r_head;
  logic                  r_shift_en;   // shift caused by a load-phase accept
  logic                  w_start_go;
  logic                  w_accept;
  logic                  w_last;

  // A start only counts from IDLE/DONE; abort always wins, including over a handshake.
  assign w_start_go = cfg_start && !cfg_abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_accept   = bs_valid && !cfg_abort && (r_state == ST_LOAD);
  assign w_last     = (r_count == c_last);

  // State register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: CLEAR and LOAD each end on their CHAIN_LEN-th event.
  always_comb begin
    w_next = r_state;
    if (cfg_abort) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (cfg_start) w_next = c_tail_chk ? ST_CLEAR : ST_LOAD;
        ST_CLEAR:         if (w_last) w_next = ST_LOAD;
        ST_LOAD:          if (w_accept && w_last) w_next = ST_DONE;
        default:          w_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: registered head/shift enable (latency 1) and the phase counter.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_count    <= '0;
      r_head     <= '0;
      r_shift_en <= 1'b0;
    end else if (cfg_abort) begin
      r_count    <= '0;
      r_shift_en <= 1'b0;
    end else if (w_start_go) begin
      r_count    <= '0;
      r_shift_en <= 1'b0;
      if (c_tail_chk) r_head <= '0;   // CLEAR shifts zeros into every chain
    end else if (r_state == ST_CLEAR) begin
      r_shift_en <= 1'b0;
      r_count    <= w_last ? '0 : r_count + c_cnt_one;
    end else begin
      r_shift_en <= w_accept;
      if (w_accept) begin
        r_head  <= bs_data;
        r_count <= r_count + c_cnt_one;
      end
    end
  end

  // Output decode; CLEAR shifts on every cycle it is resident.
  always_comb begin
    bs_ready      = (r_state == ST_LOAD);
    ccff_shift_en = r_shift_en || (r_state == ST_CLEAR);
    cfg_busy      = (r_state == ST_CLEAR) || (r_state == ST_LOAD);
    cfg_done      = (r_state == ST_DONE);
  end

  assign ccff_head   = r_head;
  assign shift_count = r_count;

`ifdef CCFF_TAIL_CHECK_EN
  ccff_tail_checker #(
    .NUM_CHAINS (NUM_CHAINS)
  ) u_tail_chk (
    .clk        (prog_clk),
    .rst        (pReset),
    .i_clear    (w_start_go),
    .i_check_en (r_shift_en),
    .i_tail     (ccff_tail),
    .o_err      (cfg_err)
  );
`else
  logic w_unused_tail;
  assign w_unused_tail = ^ccff_tail;
  assign cfg_err       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_grid_ccff_multichain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_grid_ccff_multichain_loader
// Brief    : Self-checking bench: directed table, corner sequences and random
//            traffic against a transaction-level model of the loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_grid_ccff_multichain_loader;

  localparam int NC = 4;
  localparam int CL = 8;
  localparam int CW = $clog2(CL + 1);
`ifdef CCFF_TAIL_CHECK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int NCLR = FEAT ? CL : 0;
  localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_DONE = 3;

  logic          prog_clk = 1'b0;
  logic          pReset, cfg_start, cfg_abort, bs_valid;
  logic [NC-1:0] bs_data, ccff_tail, ccff_head, cfg_err;
  logic          bs_ready, ccff_shift_en, cfg_busy, cfg_done;
  logic [CW-1:0] shift_count;

  always #5 prog_clk = ~prog_clk;

  grid_ccff_multichain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready), .ccff_head(ccff_head),
    .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .shift_count(shift_count), .cfg_err(cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level model: phase, words accepted this load, clear cycles elapsed.
  int            m_phase;
  logic [NC-1:0] m_sent[$];
  int            m_clr;
  logic [NC-1:0] m_head;
  bit            m_acc_prev;
  logic [NC-1:0] m_err;

  // Environment chains (index 0 nearest the head) and sampled pre-edge outputs.
  logic [NC-1:0] chain [0:CL-1];
  bit            stuck2 = 1'b0;
  bit            s_sen;
  logic [NC-1:0] s_head;

  typedef struct {
    bit            st;
    bit            v;
    logic [NC-1:0] d;
    bit            e_ready;
    bit            e_sen;
    logic [NC-1:0] e_head;
    int            e_cnt;
    bit            e_done;
  } vec_t;
  vec_t tbl [0:10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_IDLE; m_sent.delete(); m_clr = 0;
    m_head = '0; m_acc_prev = 1'b0; m_err = '0;
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model.
  task automatic apply(input bit st, input bit ab, input bit v, input logic [NC-1:0] d);
    bit go, acc;
    int e_cnt;
    cfg_start = st; cfg_abort = ab; bs_valid = v; bs_data = d;
    #1;
    e_cnt = (m_phase == P_CLEAR) ? m_clr :
            (m_phase == P_LOAD || m_phase == P_DONE) ? m_sent.size() : 0;
    chk("bs_ready", 32'(bs_ready), 32'(m_phase == P_LOAD));
    chk("shift_en", 32'(ccff_shift_en), 32'(m_acc_prev || m_phase == P_CLEAR));
    chk("head", 32'(ccff_head), 32'(m_head));
    chk("count", 32'(shift_count), 32'(e_cnt));
    chk("busy", 32'(cfg_busy), 32'(m_phase == P_CLEAR || m_phase == P_LOAD));
    chk("done", 32'(cfg_done), 32'(m_phase == P_DONE));
    chk("err", 32'(cfg_err), 32'(m_err));
    s_sen = ccff_shift_en; s_head = ccff_head;
    go  = st && !ab && (m_phase == P_IDLE || m_phase == P_DONE);
    acc = v && !ab && (m_phase == P_LOAD);
    if (FEAT) begin
      if (go) m_err = '0;
      else if (m_acc_prev) m_err = m_err | ccff_tail;
    end
    m_acc_prev = acc;
    if (ab) begin
      m_phase = P_IDLE; m_sent.delete(); m_clr = 0;
    end else if (go) begin
      m_sent.delete(); m_clr = 0;
      if (FEAT) begin m_phase = P_CLEAR; m_head = '0; end
      else m_phase = P_LOAD;
    end else if (m_phase == P_CLEAR) begin
      m_clr++;
      if (m_clr == CL) begin m_clr = 0; m_phase = P_LOAD; end
    end else if (acc) begin
      m_sent.push_back(d);
      m_head = d;
      if (m_sent.size() == CL) m_phase = P_DONE;
    end
  endtask

  // Clock edge; the chains shift in what the DUT presented before the edge.
  task automatic advance();
    @(posedge prog_clk);
    #1;
    if (s_sen) begin
      for (int j = CL - 1; j > 0; j--) chain[j] = chain[j-1];
      chain[0] = s_head;
    end
    ccff_tail = chain[CL-1] | (stuck2 ? 4'b0100 : 4'b0000);
    @(negedge prog_clk);
  endtask

  task automatic cyc(input bit st, input bit ab, input bit v, input logic [NC-1:0] d);
    apply(st, ab, v, d);
    advance();
  endtask

  int n_pulse;

  initial begin
    for (int j = 0; j < CL; j++) chain[j] = '0;
    ccff_tail = '0;
    pReset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
    model_reset();
    repeat (2) @(negedge prog_clk);
    pReset = 1'b0;

    // Reset state.
    cyc(0, 0, 0, '0);

    // Directed back-to-back load of words 1..CL, then two over-accept attempts.
    tbl[0] = '{st:1, v:0, d:'0, e_ready:0, e_sen:0, e_head:'0, e_cnt:0, e_done:0};
    for (int k = 1; k <= CL; k++)
      tbl[k] = '{st:0, v:1, d:NC'(k), e_ready:1, e_sen:(k > 1),
                 e_head:(k > 1) ? NC'(k-1) : NC'(0), e_cnt:k-1, e_done:0};
    tbl[CL+1] = '{st:0, v:1, d:NC'(9),  e_ready:0, e_sen:1, e_head:NC'(CL), e_cnt:CL, e_done:1};
    tbl[CL+2] = '{st:0, v:1, d:NC'(10), e_ready:0, e_sen:0, e_head:NC'(CL), e_cnt:CL, e_done:1};
    for (int r = 0; r <= CL + 2; r++) begin
      apply(tbl[r].st, 0, tbl[r].v, tbl[r].d);
      chk("tbl_ready", 32'(bs_ready), 32'(tbl[r].e_ready));
      chk("tbl_shift_en", 32'(ccff_shift_en), 32'(tbl[r].e_sen));
      chk("tbl_head", 32'(ccff_head), 32'(tbl[r].e_head));
      chk("tbl_count", 32'(shift_count), 32'(tbl[r].e_cnt));
      chk("tbl_done", 32'(cfg_done), 32'(tbl[r].e_done));
      advance();
`ifdef CCFF_TAIL_CHECK_EN
      if (r == 0) begin
        for (int c = 0; c < CL; c++) begin
          apply(0, 0, 0, '0);
          chk("clear_head", 32'(ccff_head), 32'd0);
          chk("clear_shift_en", 32'(ccff_shift_en), 32'd1);
          advance();
        end
      end
`endif
    end
    for (int j = 0; j < CL; j++) chk("chain_content", 32'(chain[j]), 32'(CL - j));

    // Gapped stream: valid on alternate cycles.
    n_pulse = 0;
    cyc(1, 0, 0, '0);
    for (int i = 0; i < NCLR + 2 * CL + 4; i++) begin
      apply(0, 0, i[0], NC'($urandom));
      n_pulse += int'(ccff_shift_en);
      advance();
    end
    chk("gapped_pulses", 32'(n_pulse), 32'(CL + NCLR));

    // Abort after three accepts, then a clean restart.
    cyc(1, 0, 0, '0);
    for (int i = 0; i < 40 && m_sent.size() < 3; i++) cyc(0, 0, 1, NC'($urandom));
    chk("abort_after3", 32'(shift_count), 32'd3);
    cyc(0, 1, 1, NC'($urandom));
    apply(0, 0, 0, '0);
    chk("abort_count", 32'(shift_count), 32'd0);
    chk("abort_done", 32'(cfg_done), 32'd0);
    chk("abort_shift_en", 32'(ccff_shift_en), 32'd0);
    chk("abort_busy", 32'(cfg_busy), 32'd0);
    advance();
    cyc(1, 0, 0, '0);
    for (int i = 0; i < NCLR + CL + 2; i++) cyc(0, 0, 1, NC'($urandom));
    chk("restart_done", 32'(cfg_done), 32'd1);

    // cfg_start while loading is ignored.
    cyc(1, 0, 0, '0);
    for (int i = 0; i < NCLR; i++) cyc(0, 0, 0, '0);
    cyc(0, 0, 1, NC'($urandom));
    cyc(0, 0, 1, NC'($urandom));
    cyc(1, 0, 1, NC'($urandom));
    cyc(1, 0, 1, NC'($urandom));
    apply(0, 0, 0, '0);
    chk("start_in_load_count", 32'(shift_count), 32'd4);
    chk("start_in_load_busy", 32'(cfg_busy), 32'd1);
    advance();

    // Asynchronous reset in the middle of a load.
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, NC'($urandom));
    apply(0, 0, 1, NC'($urandom));
    #2 pReset = 1'b1;
    #1;
    chk("rst_ready", 32'(bs_ready), 32'd0);
    chk("rst_shift_en", 32'(ccff_shift_en), 32'd0);
    chk("rst_head", 32'(ccff_head), 32'd0);
    chk("rst_count", 32'(shift_count), 32'd0);
    chk("rst_busy", 32'(cfg_busy), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);
    model_reset();
    s_sen = 1'b0;
    advance();
    pReset = 1'b0;
    cyc(1, 0, 0, '0);
    for (int i = 0; i < NCLR + CL + 1; i++) cyc(0, 0, 1, NC'($urandom));
    chk("post_rst_done", 32'(cfg_done), 32'd1);
    chk("post_rst_count", 32'(shift_count), 32'(CL));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(19, 0) == 0, $urandom_range(29, 0) == 0,
          $urandom_range(3, 0) != 0, NC'($urandom));

`ifdef CCFF_TAIL_CHECK_EN
    // Chain 2 stuck at 1 on its tail: flagged, load still completes.
    cyc(0, 1, 0, '0);
    stuck2 = 1'b1;
    ccff_tail = ccff_tail | 4'b0100;
    cyc(1, 0, 0, '0);
    for (int i = 0; i < NCLR + CL + 2; i++) cyc(0, 0, 1, NC'($urandom));
    chk("stuck_err", 32'(cfg_err), 32'h4);
    chk("stuck_done", 32'(cfg_done), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
